flag_int_unit: RTL and testbench

Flag and interrupt-request block for the RAT CPU, sitting between the ALU/control unit and the control unit's condition and interrupt inputs. Holds the C, Z and I (interrupt-enable) flags plus a C/Z shadow pair for interrupt entry/return. Synchronises and latches the external interrupt line. Drives C_FLAG, Z_FLAG and INT_CU back into the control unit every cycle.

---
 rtl/flag_int_unit.sv | 106 ++++++++++
 tb/tb_flag_int_unit.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/flag_int_unit.sv
// flag_int_unit
// Flag and interrupt-request block for the RAT CPU. It holds the carry (C),
// zero (Z) and interrupt-enable (I) flags, plus a C/Z shadow pair that is used
// on interrupt entry and return. It also synchronises the asynchronous INT_IN
// line and latches the request until the control unit acknowledges it.
//
// Parameters
//   SYNC_STAGES : synchroniser depth on INT_IN (2..4)
//   EDGE_MODE   : 1 = rising-edge request, 0 = level request
// Ports
//   CLK, RESET         : clock; synchronous active-high reset
//   ALU_C, ALU_Z       : flag results from the ALU
//   FLG_C_SET/CLR/LD   : carry force-set / force-clear / load
//   FLG_Z_LD           : zero load
//   FLG_LD_SEL         : load source, 0 = ALU, 1 = shadow
//   FLG_SHAD_LD        : copy current C/Z into the shadow pair
//   I_SET, I_CLR       : interrupt-enable set / clear (clear wins)
//   INT_ACK            : control unit took the interrupt
//   INT_IN             : external interrupt line (asynchronous)
//   C_FLAG, Z_FLAG, I_FLAG : registered flags
//   INT_CU             : pending request gated by I_FLAG
module flag_int_unit #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_MODE   = 1'b1
) (
  input  logic CLK,
  input  logic RESET,
  input  logic ALU_C,
  input  logic ALU_Z,
  input  logic FLG_C_SET,
  input  logic FLG_C_CLR,
  input  logic FLG_C_LD,
  input  logic FLG_Z_LD,
  input  logic FLG_LD_SEL,
  input  logic FLG_SHAD_LD,
  input  logic I_SET,
  input  logic I_CLR,
  input  logic INT_ACK,
  input  logic INT_IN,
  output logic C_FLAG,
  output logic Z_FLAG,
  output logic I_FLAG,
  output logic INT_CU
);

  logic c_q, z_q, shad_c, shad_z, i_q, pend, prev;
  logic [SYNC_STAGES-1:0] sync;
  logic c_nxt, z_nxt, i_nxt, pend_nxt, req;

  // Request detect. It looks only at the synchronised line, so the
  // interrupt-enable flag never masks detection. A request that arrives
  // while I=0 is held in PEND.
  assign req = EDGE_MODE ? (sync[SYNC_STAGES-1] & ~prev) : sync[SYNC_STAGES-1];

  always_comb begin
    c_nxt = c_q;
    if (FLG_C_CLR)     c_nxt = 1'b0;
    else if (FLG_C_SET) c_nxt = 1'b1;
    else if (FLG_C_LD)  c_nxt = FLG_LD_SEL ? shad_c : ALU_C;

    z_nxt = z_q;
    if (FLG_Z_LD)       z_nxt = FLG_LD_SEL ? shad_z : ALU_Z;

    i_nxt = i_q;
    if (I_CLR)          i_nxt = 1'b0;
    else if (I_SET)     i_nxt = 1'b1;

    // A new request beats the ACK. An edge that lands during the ACK cycle
    // is then not dropped.
    pend_nxt = pend;
    if (req)            pend_nxt = 1'b1;
    else if (INT_ACK)   pend_nxt = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      c_q    <= 1'b0;
      z_q    <= 1'b0;
      shad_c <= 1'b0;
      shad_z <= 1'b0;
      i_q    <= 1'b0;
      pend   <= 1'b0;
      prev   <= 1'b0;
      sync   <= '0;
    end else begin
      c_q  <= c_nxt;
      z_q  <= z_nxt;
      i_q  <= i_nxt;
      pend <= pend_nxt;
      // The shadow captures the pre-update C/Z. With FLG_LD_SEL=1 and both
      // loads active in the same cycle, the flags and the shadow swap.
      if (FLG_SHAD_LD) begin
        shad_c <= c_q;
        shad_z <= z_q;
      end
      sync <= {sync[SYNC_STAGES-2:0], INT_IN};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign C_FLAG = c_q;
  assign Z_FLAG = z_q;
  assign I_FLAG = i_q;
  assign INT_CU = pend & i_q;

endmodule

// File: tb/tb_flag_int_unit.sv
module tb_flag_int_unit;
  logic CLK = 1'b0;
  logic RESET, ALU_C, ALU_Z, FLG_C_SET, FLG_C_CLR, FLG_C_LD, FLG_Z_LD;
  logic FLG_LD_SEL, FLG_SHAD_LD, I_SET, I_CLR, INT_ACK, INT_IN;
  logic c_e, z_e, i_e, int_e;
  logic c_l, z_l, i_l, int_l;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  flag_int_unit #(.SYNC_STAGES(2), .EDGE_MODE(1'b1)) dut (
    .CLK(CLK), .RESET(RESET), .ALU_C(ALU_C), .ALU_Z(ALU_Z),
    .FLG_C_SET(FLG_C_SET), .FLG_C_CLR(FLG_C_CLR), .FLG_C_LD(FLG_C_LD),
    .FLG_Z_LD(FLG_Z_LD), .FLG_LD_SEL(FLG_LD_SEL), .FLG_SHAD_LD(FLG_SHAD_LD),
    .I_SET(I_SET), .I_CLR(I_CLR), .INT_ACK(INT_ACK), .INT_IN(INT_IN),
    .C_FLAG(c_e), .Z_FLAG(z_e), .I_FLAG(i_e), .INT_CU(int_e));

  flag_int_unit #(.SYNC_STAGES(2), .EDGE_MODE(1'b0)) dut_lvl (
    .CLK(CLK), .RESET(RESET), .ALU_C(ALU_C), .ALU_Z(ALU_Z),
    .FLG_C_SET(FLG_C_SET), .FLG_C_CLR(FLG_C_CLR), .FLG_C_LD(FLG_C_LD),
    .FLG_Z_LD(FLG_Z_LD), .FLG_LD_SEL(FLG_LD_SEL), .FLG_SHAD_LD(FLG_SHAD_LD),
    .I_SET(I_SET), .I_CLR(I_CLR), .INT_ACK(INT_ACK), .INT_IN(INT_IN),
    .C_FLAG(c_l), .Z_FLAG(z_l), .I_FLAG(i_l), .INT_CU(int_l));

  typedef struct {
    logic c_set, c_clr, c_ld, z_ld, ld_sel, shad_ld, i_set, i_clr, alu_c, alu_z;
    logic exp_c, exp_z, exp_i;
  } vec_t;
  vec_t vecs[14];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic clr_in();
    {RESET, ALU_C, ALU_Z, FLG_C_SET, FLG_C_CLR, FLG_C_LD, FLG_Z_LD} = '0;
    {FLG_LD_SEL, FLG_SHAD_LD, I_SET, I_CLR, INT_ACK} = '0;
  endtask

  initial begin
    int hi;
    //          set clr ld zld sel shd iset iclr ac az | C Z I
    vecs[0]  = '{1, 1, 1, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0}; // clear beats set/load
    vecs[1]  = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0}; // set beats load
    vecs[2]  = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 1,  1, 1, 0}; // Z load from ALU
    vecs[3]  = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0}; // C load from ALU
    vecs[4]  = '{0, 0, 0, 0, 0, 1, 0, 0, 1, 0,  0, 1, 0}; // shadow <= C0 Z1
    vecs[5]  = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0}; // C=1 Z=0
    vecs[6]  = '{0, 0, 1, 1, 1, 1, 0, 0, 1, 0,  0, 1, 0}; // swap
    vecs[7]  = '{0, 0, 1, 1, 1, 0, 0, 0, 0, 1,  1, 0, 0}; // restore from shadow
    vecs[8]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  1, 0, 1}; // I set
    vecs[9]  = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0,  1, 0, 0}; // I clear wins
    vecs[10] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  1, 0, 1};
    vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 0};
    vecs[12] = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 1,  0, 0, 0}; // force clear
    vecs[13] = '{0, 0, 1, 1, 0, 0, 0, 0, 1, 1,  1, 1, 0}; // ALU loads

    clr_in();
    INT_IN = 0;
    RESET = 1;
    step(); step(); step();
    RESET = 0;
    chk("init_c", c_e, 1'b0);
    chk("init_int", int_e, 1'b0);

    for (int k = 0; k < 14; k++) begin
      FLG_C_SET = vecs[k].c_set; FLG_C_CLR = vecs[k].c_clr; FLG_C_LD = vecs[k].c_ld;
      FLG_Z_LD = vecs[k].z_ld; FLG_LD_SEL = vecs[k].ld_sel; FLG_SHAD_LD = vecs[k].shad_ld;
      I_SET = vecs[k].i_set; I_CLR = vecs[k].i_clr; ALU_C = vecs[k].alu_c; ALU_Z = vecs[k].alu_z;
      step();
      chk($sformatf("vec%0d_c", k), c_e, vecs[k].exp_c);
      chk($sformatf("vec%0d_z", k), z_e, vecs[k].exp_z);
      chk($sformatf("vec%0d_i", k), i_e, vecs[k].exp_i);
      chk($sformatf("vec%0d_int", k), int_e, 1'b0);
    end
    clr_in();

    // Reset with every flag and the pending request set.
    FLG_C_SET = 1; FLG_Z_LD = 1; ALU_Z = 1; I_SET = 1; INT_IN = 1;
    step();
    clr_in(); INT_IN = 0;
    step(); step();
    chk("pre_rst_int", int_e, 1'b1);
    chk("pre_rst_c", c_e, 1'b1);
    RESET = 1;
    step();
    RESET = 0;
    chk("rst_c", c_e, 1'b0);
    chk("rst_z", z_e, 1'b0);
    chk("rst_i", i_e, 1'b0);
    chk("rst_int", int_e, 1'b0);

    // Edge-mode latency, ACK, and held-high input.
    I_SET = 1; step(); I_SET = 0;
    INT_IN = 1;
    step(); chk("lat_k", int_e, 1'b0);
    step(); chk("lat_k1", int_e, 1'b0);
    step(); chk("lat_k2", int_e, 1'b1);
    step(); chk("lat_k3", int_e, 1'b1);
    INT_ACK = 1; step(); INT_ACK = 0;
    chk("ack_k4", int_e, 1'b0);
    hi = 0;
    for (int n = 0; n < 10; n++) begin
      step();
      if (int_e) hi++;
    end
    chk("held_no_rereq", hi != 0, 1'b0);
    INT_IN = 0;

    // Masking, then ACK colliding with a new request.
    I_CLR = 1; step(); I_CLR = 0;
    step(); step(); step(); step();
    INT_IN = 1; step(); INT_IN = 0;
    step(); step(); step();
    chk("masked_int", int_e, 1'b0);
    I_SET = 1; step(); I_SET = 0;
    chk("unmask_int", int_e, 1'b1);
    chk("unmask_i", i_e, 1'b1);
    INT_IN = 1; step();        // edge k
    INT_IN = 0; step();        // k+1, REQ now high
    INT_ACK = 1; step();       // k+2, ACK and REQ together
    INT_ACK = 0;
    chk("ack_collide", int_e, 1'b1);
    INT_ACK = 1; step(); INT_ACK = 0;
    chk("ack_plain", int_e, 1'b0);

    // Level mode on the second instance.
    RESET = 1; step(); RESET = 0;
    chk("lvl_rst_int", int_l, 1'b0);
    I_SET = 1; I_CLR = 1; step();
    chk("lvl_i_prio", i_l, 1'b0);
    I_CLR = 0; step(); I_SET = 0;
    chk("lvl_i_set", i_l, 1'b1);
    INT_IN = 1;
    step(); step();
    chk("lvl_lat_k1", int_l, 1'b0);
    step();
    chk("lvl_lat_k2", int_l, 1'b1);
    INT_ACK = 1; step(); INT_ACK = 0;
    chk("lvl_ack_ignored", int_l, 1'b1);
    INT_IN = 0; INT_ACK = 1;
    step(); chk("lvl_drop_j", int_l, 1'b1);
    step(); chk("lvl_drop_j1", int_l, 1'b1);
    step(); chk("lvl_drop_j2", int_l, 1'b0);
    INT_ACK = 0;
    step(); chk("lvl_idle", int_l, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
